coinc_count_bank: RTL and testbench

- Parametrised, windowed pulse-counter bank for the coincidence counting unit.
- Counts rising edges on NUM_CH single-cycle or level pulse lines (singles A/B/A'/B' and coincidence channels) over a programmable gate window of clock cycles.
- At window end, atomically snapshots all channels into an output register bank with a valid strobe, saturation flags and a batch index.
- Supports single-shot and continuous back-to-back batches with no dead time; feeds the readout/transmit path.

---
 rtl/coinc_count_bank.sv | 144 ++++++++++++++
 tb/tb_coinc_count_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coinc_count_bank.sv
// coinc_count_bank: windowed rising-edge counter bank for the coincidence unit.
// Counts rising edges on NUM_CH pulse lines over a programmable gate window,
// then snapshots every channel at once into a held output bank with a strobe.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   pulse[NUM_CH]      pulse lines, synchronous to clk
//   window_cycles      gate length in cycles (0 behaves as 1), sampled at batch start
//   start / stop       begin (IDLE only) / abort (RUN only)
//   continuous         restart a new batch at window end, sampled at window end
//   busy               high while acquiring
//   counts, sat        snapshot bank (channel i at [i*CNT_W +: CNT_W]) and sat flags
//   counts_valid       one-cycle strobe when a new snapshot lands
//   batch_id           index of the batch held in counts

// Per-channel edge detector, saturating accumulator and snapshot register.
module coinc_ch_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             clr,    // start of a batch: zero acc/ovf
  input  logic             en,     // counting cycle
  input  logic             snap,   // terminal cycle: capture acc+rise
  output logic [CNT_W-1:0] counts,
  output logic             sat
);
  logic             pulse_d;
  logic [CNT_W-1:0] acc;
  logic             ovf;
  logic             rise, at_max, new_sat;
  logic [CNT_W-1:0] sum;

  assign rise    = pulse & ~pulse_d;
  assign at_max  = &acc;
  assign new_sat = rise & at_max;
  assign sum     = at_max ? acc : acc + {{(CNT_W-1){1'b0}}, rise};

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_d <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
      counts  <= '0;
      sat     <= 1'b0;
    end else begin
      // Edge history tracks in every state so a level held across start is not an edge.
      pulse_d <= pulse;
      // clr wins over en: the terminal cycle's rise goes to the snapshot, and
      // the following cycle starts the next batch from zero.
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (en) begin
        acc <= sum;
        ovf <= ovf | new_sat;
      end
      if (snap) begin
        counts <= sum;
        sat    <= ovf | new_sat;
      end
    end
  end
endmodule

module coinc_count_bank #(
  parameter int NUM_CH = 9,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 32,
  parameter int BID_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pulse,
  input  logic [WIN_W-1:0]        window_cycles,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  output logic                    busy,
  output logic [NUM_CH*CNT_W-1:0] counts,
  output logic [NUM_CH-1:0]       sat,
  output logic                    counts_valid,
  output logic [BID_W-1:0]        batch_id
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [WIN_W-1:0] ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] win_len;
  logic             run, terminal, clr;

  assign run      = (state == S_RUN);
  assign terminal = run & (timer == ONE);
  assign win_len  = (window_cycles == '0) ? ONE : window_cycles;
  // Clearing on every terminal is harmless when returning to IDLE (next start clears again).
  assign clr      = ((state == S_IDLE) & start) | terminal;
  assign busy     = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      batch_id     <= '0;
      counts_valid <= 1'b0;
    end else begin
      counts_valid <= terminal;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            timer <= win_len;
          end
        end
        default: begin
          if (terminal) begin
            batch_id <= batch_id + 1'b1;
            // stop in the terminal cycle still completes the batch, then idles.
            if (continuous & ~stop) timer <= win_len;
            else                    state <= S_IDLE;
          end else if (stop) begin
            state <= S_IDLE;
          end else begin
            timer <= timer - ONE;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    coinc_ch_cnt #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .pulse  (pulse[i]),
      .clr    (clr),
      .en     (run),
      .snap   (terminal),
      .counts (counts[i*CNT_W +: CNT_W]),
      .sat    (sat[i])
    );
  end
endmodule

// File: tb/tb_coinc_count_bank.sv
// Directed bench for coinc_count_bank. Expected snapshots are queued when a
// batch is started; a negedge monitor pops and compares on each counts_valid.
module tb_coinc_count_bank;
  localparam int NUM_CH = 9;
  localparam int CNT_W  = 4;
  localparam int WIN_W  = 32;
  localparam int BID_W  = 8;
  localparam int CW     = NUM_CH*CNT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] pulse;
  logic [WIN_W-1:0]  window_cycles;
  logic              start, stop, continuous;
  logic              busy;
  logic [CW-1:0]     counts;
  logic [NUM_CH-1:0] sat;
  logic              counts_valid;
  logic [BID_W-1:0]  batch_id;

  typedef struct {
    logic [CW-1:0]     c;
    logic [NUM_CH-1:0] s;
    logic [BID_W-1:0]  b;
  } exp_t;

  exp_t             sb[$];
  logic [BID_W-1:0] exp_bid;
  int               n_chk = 0;
  int               n_fail = 0;

  coinc_count_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .BID_W(BID_W)) dut (
    .clk(clk), .rst(rst), .pulse(pulse), .window_cycles(window_cycles),
    .start(start), .stop(stop), .continuous(continuous), .busy(busy),
    .counts(counts), .sat(sat), .counts_valid(counts_valid), .batch_id(batch_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cv(input int ch, input int val);
    logic [CW-1:0] v;
    v = '0;
    v[ch*CNT_W +: CNT_W] = CNT_W'(val);
    return v;
  endfunction

  task automatic push(input logic [CW-1:0] c, input logic [NUM_CH-1:0] s);
    exp_t e;
    exp_bid = exp_bid + 1'b1;
    e.c = c; e.s = s; e.b = exp_bid;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then step past the edge that samples them.
  task automatic cyc(input logic [NUM_CH-1:0] p, input logic st, input logic sp, input logic cont);
    pulse = p; start = st; stop = sp; continuous = cont;
    tick();
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && counts_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("snap_counts", 64'(counts), 64'(e.c));
        check("snap_sat", 64'(sat), 64'(e.s));
        check("snap_bid", 64'(batch_id), 64'(e.b));
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0] p;
    pulse = '0; start = 0; stop = 0; continuous = 0; window_cycles = '0; rst = 1'b1;
    exp_bid = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_counts", 64'(counts), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    check("rst_valid", 64'(counts_valid), 64'd0);
    check("rst_bid", 64'(batch_id), 64'd0);
    cyc('0, 0, 0, 0);

    // Basic single-shot window of 10
    window_cycles = 10;
    push(cv(0,3) | cv(4,5), '0);
    cyc('0, 1, 0, 0);
    check("t1_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 10; k++) begin
      p = '0;
      p[0] = (k == 1 || k == 3 || k == 5);
      p[4] = (k % 2 == 1);
      cyc(p, 0, 0, 0);
      if (k == 9) check("t1_novalid_early", 64'(counts_valid), 64'd0);
    end
    check("t1_valid", 64'(counts_valid), 64'd1);
    check("t1_busy_fall", 64'(busy), 64'd0);
    cyc('0, 0, 0, 0);
    check("t1_valid_one_cycle", 64'(counts_valid), 64'd0);

    // Boundary edges, single mode: t (ch1), t+1/t+10 (ch2), t+11 (ch3)
    push(cv(2,2), '0);
    p = '0; p[1] = 1'b1;
    cyc(p, 1, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      p = '0;
      p[2] = (k == 1 || k == 10);
      p[3] = (k == 11);
      cyc(p, 0, 0, 0);
      if (k == 10) check("t2_valid", 64'(counts_valid), 64'd1);
    end
    check("t2_idle", 64'(busy), 64'd0);
    cyc('0, 0, 0, 0);

    // Boundary edges, continuous: second batch owns the t+11 edge
    push(cv(2,2), '0);
    push(cv(3,1), '0);
    p = '0; p[1] = 1'b1;
    cyc(p, 1, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      p = '0;
      p[2] = (k == 1 || k == 10);
      p[3] = (k == 11);
      cyc(p, 0, 0, k < 20);
      if (k == 10) begin
        check("t2c_valid1", 64'(counts_valid), 64'd1);
        check("t2c_busy_kept", 64'(busy), 64'd1);
      end
      if (k == 11) check("t2c_valid1_len", 64'(counts_valid), 64'd0);
    end
    check("t2c_valid2", 64'(counts_valid), 64'd1);
    check("t2c_idle", 64'(busy), 64'd0);
    cyc('0, 0, 0, 0);

    // Saturation: 20 edges into a 4-bit counter, then a clean window
    window_cycles = 50;
    push(cv(1,15), 9'b000000010);
    push(cv(1,2), '0);
    cyc('0, 1, 0, 1);
    for (int k = 1; k <= 100; k++) begin
      p = '0;
      p[1] = (k <= 39 && k % 2 == 1) || k == 51 || k == 53;
      cyc(p, 0, 0, k < 100);
      if (k == 50 || k == 100) check("t3_valid", 64'(counts_valid), 64'd1);
    end
    cyc('0, 0, 0, 0);

    // Abort: a good batch, then a stopped one
    window_cycles = 10;
    push(cv(0,3), '0);
    cyc('0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      p = '0; p[0] = (k == 2 || k == 4 || k == 6);
      cyc(p, 0, 0, 0);
    end
    cyc('0, 0, 0, 0);
    cyc('0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      p = '0; p[0] = (k == 1 || k == 3);
      cyc(p, 0, k == 5, 0);
    end
    check("t4_abort_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 12; k++) cyc('0, 0, 0, 0);
    check("t4_counts_kept", 64'(counts), 64'(cv(0,3)));
    check("t4_bid_kept", 64'(batch_id), 64'(exp_bid));

    // stop coincident with the terminal cycle: completes, then idles
    push(cv(0,1), '0);
    cyc('0, 1, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      p = '0; p[0] = (k == 2);
      cyc(p, 0, k == 10, 1);
    end
    check("t4_stopterm_valid", 64'(counts_valid), 64'd1);
    check("t4_stopterm_idle", 64'(busy), 64'd0);
    cyc('0, 0, 0, 0);
    cyc('0, 0, 0, 0);

    // Reset mid-window
    cyc('0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      p = '0; p[0] = (k == 1 || k == 3);
      cyc(p, 0, 0, 0);
    end
    rst = 1'b1;
    cyc('0, 0, 0, 0);
    rst = 1'b0;
    exp_bid = '0;
    check("t5_counts", 64'(counts), 64'd0);
    check("t5_bid", 64'(batch_id), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_valid", 64'(counts_valid), 64'd0);
    window_cycles = 3;
    push('0, '0);
    cyc('0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) cyc('0, 0, 0, 0);
    check("t5_restart_valid", 64'(counts_valid), 64'd1);
    cyc('0, 0, 0, 0);

    // Level held high across start counts nothing
    window_cycles = 5;
    p = '0; p[5] = 1'b1;
    cyc(p, 0, 0, 0);
    push('0, '0);
    cyc(p, 1, 0, 0);
    for (int k = 1; k <= 5; k++) cyc(p, 0, 0, 0);
    check("t6_level_valid", 64'(counts_valid), 64'd1);
    cyc('0, 0, 0, 0);

    // Zero window acts as one cycle: valid at t+2
    window_cycles = 0;
    push(cv(0,1), '0);
    cyc('0, 1, 0, 0);
    p = '0; p[0] = 1'b1;
    cyc(p, 0, 0, 0);
    check("t6_zero_valid", 64'(counts_valid), 64'd1);
    check("t6_zero_idle", 64'(busy), 64'd0);
    for (int k = 0; k < 4; k++) cyc('0, 0, 0, 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
